// File: rtl/lvds_packer_be.sv
// lvds_packer_be: packs IN_LEN-bit samples little-endian into DATA_LEN-bit words with byte enables; define LVDS_PACKER_TIMEOUT_EN for idle auto-flush
module lvds_packer_be #(
  parameter int IN_LEN   = 8,
  parameter int DATA_LEN = 32,
  parameter int BE_LEN   = DATA_LEN/8,
  parameter int TIMEOUT  = 16,
  parameter int CNT_LEN  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                valid_i,
  input  logic [IN_LEN-1:0]   data_i,
  input  logic                flush_i,
  input  logic                full_i,
  output logic                valid_o,
  output logic [DATA_LEN-1:0] data_o,
  output logic [BE_LEN-1:0]   be_o,
  output logic                overflow_o,
  output logic [CNT_LEN-1:0]  drop_cnt_o
);
  localparam int LANES = DATA_LEN/IN_LEN;
  localparam int BPL   = IN_LEN/8;
  localparam int CW    = $clog2(LANES+1);
  typedef enum logic {EMPTY, FILLING} state_t;
  state_t state, state_d;
  logic [CW-1:0] cnt, cnt_n;
  logic [DATA_LEN-1:0] acc, acc_n;
  logic [BE_LEN-1:0] be_n;
  logic full_word, tmo, emit;
`ifdef LVDS_PACKER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT+1);
  logic [TW-1:0] timer;
  assign tmo = state == FILLING && !valid_i && timer == TW'(TIMEOUT-1);
  // idle timer: counts sample-free cycles while a partial word is held
  always_ff @(posedge clk)
    if (rst || valid_i || emit || state == EMPTY) timer <= '0;
    else timer <= timer + TW'(1);
`else
  assign tmo = 1'b0;
`endif
  // next lane fill, byte enables of the word being formed, and emit decision
  always_comb begin
    cnt_n = cnt + CW'(valid_i);
    acc_n = acc;
    be_n = '0;
    for (int l = 0; l < LANES; l++) begin
      if (valid_i && cnt == CW'(l)) acc_n[l*IN_LEN +: IN_LEN] = data_i;
      be_n[l*BPL +: BPL] = {BPL{CW'(l) < cnt_n}};
    end
    full_word = valid_i && cnt == CW'(LANES-1);
    emit = full_word || (flush_i && cnt_n != '0) || tmo;
    state_d = (emit || cnt_n == '0) ? EMPTY : FILLING;
  end
  // state register
  always_ff @(posedge clk)
    if (rst) state <= EMPTY;
    else state <= state_d;
  // accumulator, output word register and drop accounting
  always_ff @(posedge clk)
    if (rst) begin
      cnt <= '0;
      acc <= '0;
      valid_o <= 1'b0;
      data_o <= '0;
      be_o <= '0;
      overflow_o <= 1'b0;
      drop_cnt_o <= '0;
    end else begin
      cnt <= emit ? '0 : cnt_n;
      acc <= emit ? '0 : acc_n;
      valid_o <= emit && !full_i;
      if (emit && !full_i) begin
        data_o <= acc_n;
        be_o <= be_n;
      end
      if (emit && full_i) begin
        overflow_o <= 1'b1;
        if (drop_cnt_o != '1) drop_cnt_o <= drop_cnt_o + CNT_LEN'(1);
      end
    end
endmodule
